// File: rtl/ffd_sync_debounce.sv
// N-channel input conditioner: STAGES-deep synchroniser, per-channel debounce
// counter and registered one-cycle RISE/FALL strobes, all on CLK.
module ffd_sync_debounce #(
   parameter int N          = 1,
   parameter int STAGES     = 2,
   parameter int DEB_CYCLES = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q,
   output logic [N-1:0] RISE,
   output logic [N-1:0] FALL
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [STAGES-1:0][N-1:0] sync;
   logic [N-1:0]             y;
   logic [N-1:0][CW-1:0]     cnt;

   // Free-running shift chain; only the last stage is ever observed.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync <= '0;
      end else begin
         sync <= {sync[STAGES-2:0], D};
      end
   end

   assign y = sync[STAGES-1];

   // A new level must persist for DEB_CYCLES enabled samples before Q accepts it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Q    <= '0;
         cnt  <= '0;
         RISE <= '0;
         FALL <= '0;
      end else begin
         RISE <= '0;
         FALL <= '0;
         if (EN) begin
            for (int i = 0; i < N; i++) begin
               if (y[i] == Q[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_MAX) begin
                  Q[i]    <= y[i];
                  cnt[i]  <= '0;
                  RISE[i] <= y[i];
                  FALL[i] <= ~y[i];
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end
         end
      end
   end

endmodule

// File: doc/ffd_sync_debounce.md
Name: ffd_sync_debounce

Overview:
- N-channel parametrised successor to the single-stage FFD register. Each channel has a STAGES-deep synchroniser, a per-channel debounce counter, and registered edge pulses.
- Sits between the raw fire-machine inputs and the control FSMs: flame/temperature sensors, limit switches and push-buttons.
- Every output is a clean, metastability-hardened level on CLK, plus one-cycle RISE/FALL strobes for the controller.

Parameters:
- N, 1, number of independent input channels.
- STAGES, 2, synchroniser flip-flops per channel; legal values ≥2.
- DEB_CYCLES, 4, number of consecutive enabled samples the synchronised input must hold a new value before Q accepts it; legal values ≥1.
- CW, max(1, clog2(DEB_CYCLES)), counter width per channel; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- EN  input  1  sample enable (tie high, or drive with a slow tick for longer debounce windows).
- D  input  N  raw asynchronous channel inputs.
- Q  output  N  debounced levels, registered.
- RISE  output  N  one-cycle pulse when Q[i] goes 0→1.
- FALL  output  N  one-cycle pulse when Q[i] goes 1→0.

Behaviour:
- Reset: while RST=1, asynchronously clear all synchroniser stages, Q, counters, RISE and FALL to 0. Release takes effect on the first CLK edge with RST=0.
- Reset mid-operation: clears everything immediately, including any partial count and any pulse in flight.
- Synchroniser (per channel i): always runs, independent of EN.
  - s0[i] ← D[i]; sk[i] ← s(k-1)[i].
  - y[i] = s(STAGES-1)[i].
  - No logic taps any stage before y.
- Debounce, EN=1, per channel:
  - If y[i]==Q[i]: cnt[i] ← 0.
  - Else if cnt[i]==DEB_CYCLES-1: Q[i] ← y[i]; cnt[i] ← 0; pulse RISE[i] if y[i]=1, else FALL[i].
  - Else: cnt[i] ← cnt[i]+1.
- Debounce, EN=0: Q and cnt hold; RISE=FALL=0.
- Pulses are registered and change on the same edge as Q. They last exactly one CLK cycle. RISE[i] and FALL[i] are never both 1.
- Latency (EN tied high): D[i] changes before edge 1 and stays stable → Q[i] changes on edge STAGES+DEB_CYCLES.
  - Default parameters: edge 6.
  - DEB_CYCLES=1: edge STAGES+1.
- Glitch rejection: if y[i] returns to Q[i] before the count completes, cnt clears and Q does not change. Any pulse on D shorter than DEB_CYCLES enabled samples, as seen at y, is rejected.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Counter never exceeds DEB_CYCLES-1; no wrap-around is possible.
- Outputs are purely registered, with no combinational path from D.

Test Plan:
- Reset: assert RST asynchronously mid-cycle with D=all 1s and counts in progress → Q=RISE=FALL=0 immediately, with no CLK edge needed. After release, a held D=1 gives Q=1 on edge 6.
- Latency (N=1, STAGES=2, DEB_CYCLES=4, EN=1): D 0→1 before edge 1 → Q=1 and RISE=1 on edge 6 only. D 1→0 → FALL=1 exactly 6 edges later.
- Glitch: D=1 for 3 cycles then 0 → Q stays 0; RISE never asserts; cnt returns to 0.
- EN gating: EN pulses high every 4th cycle, D held at 1 → Q rises on the 4th enabled edge after y=1 (edge 2+13=15 from D change, given EN first high at edge 3). Q holds while EN=0.
- Multi-channel (N=4): D=4'b1010, then 4'b0101 after Q settles → FALL=4'b1010 and RISE=4'b0101 in the same cycle; Q=4'b0101.
- DEB_CYCLES=1, STAGES=3: D toggles every 8 cycles → Q tracks D delayed by 4 edges, one pulse per toggle.
